// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready
// producers, granting bursts of up to MAX_BURST beats and tagging each beat
// with its source ID.
// Ports:
//   clock, rst           clock, asynchronous active-low reset
//   req_valid/req_data   per-producer valid and flattened data (producer i at
//                        [i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready            per-producer ready, one-hot or zero
//   fifo_full            FIFO full flag
//   fifo_wr_en/fifo_din  FIFO write enable and data
//   fifo_id              source ID of the current beat (sideband ID FIFO)
//   grant_id             currently granted producer
//   busy                 high while a producer holds the grant
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BURST  = 4,
  localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                            clock,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_din,
  output logic [ID_WIDTH-1:0]             fifo_id,
  output logic [ID_WIDTH-1:0]             grant_id,
  output logic                            busy
);

  localparam int unsigned CNT_WIDTH = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

  logic                  arb_found;
  logic [ID_WIDTH-1:0]   arb_id;
  logic [ID_WIDTH-1:0]   arb_base;
  logic [ID_WIDTH-1:0]   arb_cand;
  logic [CNT_WIDTH-1:0]  beat_inc;
  logic                  sel_valid;

  // Round-robin search starting one past the base, explicit modulo wrap.
  // While granted, the base is the current owner so a releasing producer
  // ranks last in the same-edge re-arbitration.
  always_comb begin : arb_search
    arb_found = 1'b0;
    arb_id    = '0;
    arb_cand  = '0;
    arb_base  = (state_q == GRANT) ? grant_id_q : last_grant_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      arb_cand = ID_WIDTH'((32'(arb_base) + k) % NUM_REQ);
      if (!arb_found && req_valid[arb_cand]) begin
        arb_found = 1'b1;
        arb_id    = arb_cand;
      end
    end
  end

  // Write-port drive; control depends only on state, req_valid and fifo_full.
  always_comb begin : port_drive
    req_ready  = '0;
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    busy       = 1'b0;
    sel_valid  = req_valid[grant_id_q];
    if (state_q == GRANT) begin
      busy                  = 1'b1;
      req_ready[grant_id_q] = !fifo_full;
      fifo_wr_en            = sel_valid & !fifo_full;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant_id_q == ID_WIDTH'(i)) begin
          fifo_din = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign fifo_id  = grant_id_q;
  assign grant_id = grant_id_q;

  // Next-state: grant, burst counting, release and same-edge re-arbitration.
  always_comb begin : next_state
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    beat_inc     = beat_cnt_q + CNT_WIDTH'(1);
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d    = GRANT;
          grant_id_d = arb_id;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (fifo_wr_en) begin
          beat_cnt_d = beat_inc;
        end
        // Release on a completed burst or a dropped valid (even when full).
        if (!sel_valid || (fifo_wr_en && (beat_inc == CNT_WIDTH'(MAX_BURST)))) begin
          last_grant_d = grant_id_q;
          beat_cnt_d   = '0;
          if (arb_found) begin
            grant_id_d = arb_id;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; after reset producer 0 is first in line.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_id_q   <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: two instances (4 producers / burst 4 and
// 3 producers / burst 2) checked every cycle against a transaction-level
// round-robin model, plus directed scenarios with literal expectations and
// an in-order per-producer stream check under random load.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 16;

  logic        clock;
  logic        rst;

  logic [3:0]    a_valid;
  logic [4*DW-1:0] a_data;
  logic [3:0]    a_ready;
  logic          a_full;
  logic          a_wr;
  logic [DW-1:0] a_din;
  logic [1:0]    a_fid;
  logic [1:0]    a_gid;
  logic          a_busy;

  logic [2:0]    b_valid;
  logic [3*DW-1:0] b_data;
  logic [2:0]    b_ready;
  logic          b_full;
  logic          b_wr;
  logic [DW-1:0] b_din;
  logic [1:0]    b_fid;
  logic [1:0]    b_gid;
  logic          b_busy;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(DW), .MAX_BURST(4)) dut_a (
    .clock(clock), .rst(rst), .req_valid(a_valid), .req_data(a_data),
    .req_ready(a_ready), .fifo_full(a_full), .fifo_wr_en(a_wr),
    .fifo_din(a_din), .fifo_id(a_fid), .grant_id(a_gid), .busy(a_busy)
  );

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(DW), .MAX_BURST(2)) dut_b (
    .clock(clock), .rst(rst), .req_valid(b_valid), .req_data(b_data),
    .req_ready(b_ready), .fifo_full(b_full), .fifo_wr_en(b_wr),
    .fifo_din(b_din), .fifo_id(b_fid), .grant_id(b_gid), .busy(b_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit stream_en = 1'b0;

  // Reference model per instance: who owns the port, beats sent so far in
  // the current grant, and who released last.
  int m_act[2];
  int m_own[2];
  int m_beats[2];
  int m_last[2];

  int sa[4], sb[3];   // handshakes accepted per producer
  int wa[4], wb[3];   // beats observed on the write port per producer

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int last, input int v, input int n);
    for (int k = 1; k <= n; k++) begin
      int idx;
      idx = (last + k) % n;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_act  = '{0, 0};
    m_own  = '{0, 0};
    m_beats = '{0, 0};
    m_last = '{3, 2};
  endtask

  task automatic model_step(input int i, input int n, input int mb, input int v, input int full);
    int p;
    if (m_act[i] == 0) begin
      p = pick(m_last[i], v, n);
      if (p >= 0) begin
        m_act[i] = 1; m_own[i] = p; m_beats[i] = 0;
      end
    end else begin
      if (v[m_own[i]] && full == 0) m_beats[i]++;
      if (!v[m_own[i]] || m_beats[i] == mb) begin
        m_last[i] = m_own[i];
        p = pick(m_last[i], v, n);
        m_beats[i] = 0;
        if (p >= 0) m_own[i] = p;
        else m_act[i] = 0;
      end
    end
  endtask

  always @(posedge clock or negedge rst) begin
    if (!rst) model_reset();
    else begin
      model_step(0, 4, 4, int'(a_valid), int'(a_full));
      model_step(1, 3, 2, int'(b_valid), int'(b_full));
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clock) begin
    logic [63:0] er;
    if (!rst) begin
      chk("rst_a_busy", 64'(a_busy), 64'd0);
      chk("rst_a_wr", 64'(a_wr), 64'd0);
      chk("rst_a_ready", 64'(a_ready), 64'd0);
      chk("rst_a_din", 64'(a_din), 64'd0);
      chk("rst_a_gid", 64'(a_gid), 64'd0);
      chk("rst_b_busy", 64'(b_busy), 64'd0);
      chk("rst_b_wr", 64'(b_wr), 64'd0);
      chk("rst_b_ready", 64'(b_ready), 64'd0);
      chk("rst_b_fid", 64'(b_fid), 64'd0);
    end else begin
      chk("mdl_a_busy", 64'(a_busy), 64'(m_act[0]));
      er = (m_act[0] != 0 && !a_full) ? (64'd1 << m_own[0]) : 64'd0;
      chk("mdl_a_ready", 64'(a_ready), er);
      chk("mdl_a_wr", 64'(a_wr), 64'(m_act[0] != 0 && a_valid[m_own[0]] && !a_full));
      if (m_act[0] != 0) begin
        chk("mdl_a_gid", 64'(a_gid), 64'(m_own[0]));
        chk("mdl_a_fid", 64'(a_fid), 64'(m_own[0]));
        chk("mdl_a_din", 64'(a_din), 64'(a_data[m_own[0]*DW +: DW]));
      end
      chk("mdl_b_busy", 64'(b_busy), 64'(m_act[1]));
      er = (m_act[1] != 0 && !b_full) ? (64'd1 << m_own[1]) : 64'd0;
      chk("mdl_b_ready", 64'(b_ready), er);
      chk("mdl_b_wr", 64'(b_wr), 64'(m_act[1] != 0 && b_valid[m_own[1]] && !b_full));
      if (m_act[1] != 0) begin
        chk("mdl_b_gid", 64'(b_gid), 64'(m_own[1]));
        chk("mdl_b_fid", 64'(b_fid), 64'(m_own[1]));
        chk("mdl_b_din", 64'(b_din), 64'(b_data[m_own[1]*DW +: DW]));
      end
      // Each producer's beats must reach the FIFO in order, none lost or doubled.
      if (stream_en && a_wr) begin
        chk("a_stream", 64'(a_din), 64'({4'(a_fid), 12'(wa[a_fid])}));
        wa[a_fid]++;
      end
      if (stream_en && b_wr) begin
        chk("b_stream", 64'(b_din), 64'({4'(b_fid), 12'(wb[b_fid])}));
        wb[b_fid]++;
      end
    end
  end

  task automatic set_a(input int p, input logic [DW-1:0] v);
    a_data[p*DW +: DW] = v;
  endtask

  task automatic set_b(input int p, input logic [DW-1:0] v);
    b_data[p*DW +: DW] = v;
  endtask

  task automatic post();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    a_valid = '0; b_valid = '0; a_full = 1'b0; b_full = 1'b0;
    post();
    chk("rst_lit_busy", 64'(a_busy), 64'd0);
    chk("rst_lit_gid", 64'(a_gid), 64'd0);
    post();
    rst = 1'b1;
  endtask

  task automatic rand_cycle(input int thr);
    logic [3:0] hs_a;
    logic [2:0] hs_b;
    @(negedge clock);
    hs_a = a_valid & a_ready;
    hs_b = b_valid & b_ready;
    post();
    for (int p = 0; p < 4; p++) begin
      if (hs_a[p]) sa[p]++;
      if (a_valid[p] && !hs_a[p]) begin
        if ($urandom_range(7) == 0) a_valid[p] = 1'b0;
      end else begin
        a_valid[p] = ($urandom_range(9) < thr);
      end
      set_a(p, {4'(p), 12'(sa[p])});
    end
    for (int p = 0; p < 3; p++) begin
      if (hs_b[p]) sb[p]++;
      if (b_valid[p] && !hs_b[p]) begin
        if ($urandom_range(7) == 0) b_valid[p] = 1'b0;
      end else begin
        b_valid[p] = ($urandom_range(9) < thr);
      end
      set_b(p, {4'(p), 12'(sb[p])});
    end
    a_full = ($urandom_range(4) == 0);
    b_full = ($urandom_range(3) == 0);
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    a_valid = '0; b_valid = '0; a_data = '0; b_data = '0;
    a_full = 1'b0; b_full = 1'b0;

    // Single producer 2, six beats across two bursts.
    do_reset();
    a_valid = 4'b0100;
    set_a(2, 16'h10);
    @(negedge clock);
    chk("t1_first_idle", 64'(a_wr), 64'd0);
    post();
    for (int b = 0; b < 6; b++) begin
      @(negedge clock);
      chk("t1_wr", 64'(a_wr), 64'd1);
      chk("t1_din", 64'(a_din), 64'(16'h10 + b));
      chk("t1_fid", 64'(a_fid), 64'd2);
      post();
      set_a(2, 16'(16'h10 + b + 1));
    end
    a_valid = '0;

    // All four producers valid: 0,1,2,3 with 4 beats each, no gaps.
    do_reset();
    for (int p = 0; p < 4; p++) set_a(p, 16'(p * 256));
    a_valid = 4'hf;
    @(negedge clock);
    chk("t2_first_idle", 64'(a_wr), 64'd0);
    post();
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      chk("t2_wr", 64'(a_wr), 64'd1);
      chk("t2_fid", 64'(a_fid), 64'(k / 4));
      chk("t2_din", 64'(a_din), 64'((k / 4) * 256 + (k % 4)));
      post();
      set_a(k / 4, 16'((k / 4) * 256 + (k % 4) + 1));
    end
    a_valid = '0;

    // FIFO full for 3 cycles after beat 2 of producer 1; then handoff to 3.
    do_reset();
    set_a(1, 16'h20); set_a(3, 16'h30);
    a_valid = 4'b1010;
    @(negedge clock);
    chk("t3_first_idle", 64'(a_wr), 64'd0);
    post();
    for (int b = 0; b < 2; b++) begin
      @(negedge clock);
      chk("t3_wr", 64'(a_wr), 64'd1);
      chk("t3_din", 64'(a_din), 64'(16'h20 + b));
      post();
      set_a(1, 16'(16'h20 + b + 1));
    end
    a_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("t3_full_wr", 64'(a_wr), 64'd0);
      chk("t3_full_ready", 64'(a_ready), 64'd0);
      chk("t3_full_gid", 64'(a_gid), 64'd1);
      post();
    end
    a_full = 1'b0;
    for (int b = 2; b < 4; b++) begin
      @(negedge clock);
      chk("t3_resume_wr", 64'(a_wr), 64'd1);
      chk("t3_resume_din", 64'(a_din), 64'(16'h20 + b));
      chk("t3_resume_fid", 64'(a_fid), 64'd1);
      post();
      set_a(1, 16'(16'h20 + b + 1));
    end
    a_valid[1] = 1'b0;
    @(negedge clock);
    chk("t3_next_fid", 64'(a_fid), 64'd3);
    chk("t3_next_din", 64'(a_din), 64'h30);
    chk("t3_next_wr", 64'(a_wr), 64'd1);
    post();
    a_valid = '0;

    // Producer 0 drops valid after one beat while producer 3 waits.
    do_reset();
    set_a(0, 16'h50); set_a(3, 16'h53);
    a_valid = 4'b1001;
    @(negedge clock);
    chk("t4_first_idle", 64'(a_wr), 64'd0);
    post();
    @(negedge clock);
    chk("t4_beat_fid", 64'(a_fid), 64'd0);
    chk("t4_beat_din", 64'(a_din), 64'h50);
    post();
    a_valid[0] = 1'b0;
    @(negedge clock);
    chk("t4_gap_wr", 64'(a_wr), 64'd0);
    chk("t4_gap_busy", 64'(a_busy), 64'd1);
    post();
    @(negedge clock);
    chk("t4_p3_gid", 64'(a_gid), 64'd3);
    chk("t4_p3_wr", 64'(a_wr), 64'd1);
    chk("t4_p3_din", 64'(a_din), 64'h53);
    post();
    a_valid = '0;

    // Three producers: 0 and 1 together from last_grant 2, then 2 skipped.
    do_reset();
    for (int p = 0; p < 3; p++) set_b(p, 16'(16'h300 + p));
    b_valid = 3'b011;
    @(negedge clock);
    chk("t5_first_idle", 64'(b_wr), 64'd0);
    post();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("t5_wr", 64'(b_wr), 64'd1);
      chk("t5_fid", 64'(b_fid), 64'((c < 2) ? 0 : (c < 4) ? 1 : 0));
      post();
    end
    b_valid = '0;

    // Asynchronous reset mid-burst, then producer 0 wins over producer 1.
    do_reset();
    set_a(1, 16'h40);
    a_valid = 4'b0010;
    @(negedge clock);
    chk("t6_first_idle", 64'(a_wr), 64'd0);
    post();
    @(negedge clock);
    chk("t6_beat1", 64'(a_din), 64'h40);
    post();
    set_a(1, 16'h41);
    @(negedge clock);
    chk("t6_beat2", 64'(a_din), 64'h41);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_wr", 64'(a_wr), 64'd0);
    chk("t6_rst_ready", 64'(a_ready), 64'd0);
    chk("t6_rst_busy", 64'(a_busy), 64'd0);
    chk("t6_rst_din", 64'(a_din), 64'd0);
    chk("t6_rst_fid", 64'(a_fid), 64'd0);
    post();
    post();
    rst = 1'b1;
    set_a(0, 16'h60);
    a_valid = 4'b0011;
    @(negedge clock);
    chk("t6_after_idle", 64'(a_wr), 64'd0);
    post();
    @(negedge clock);
    chk("t6_after_gid", 64'(a_gid), 64'd0);
    chk("t6_after_din", 64'(a_din), 64'h60);
    post();
    a_valid = '0;

    // Random load on both instances with the stream check enabled.
    do_reset();
    for (int p = 0; p < 4; p++) begin sa[p] = 0; wa[p] = 0; set_a(p, {4'(p), 12'd0}); end
    for (int p = 0; p < 3; p++) begin sb[p] = 0; wb[p] = 0; set_b(p, {4'(p), 12'd0}); end
    stream_en = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rand_cycle(1 + (cyc / 400) % 10);
    end
    stream_en = 1'b0;
    a_valid = '0; b_valid = '0; a_full = 1'b0; b_full = 1'b0;
    repeat (4) post();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
